// File: rtl/operand_stage_if.sv
// Handshake bundle between the operand producer, the staging FIFO and the consumer.
// The stage takes the slave view; the driving environment takes the master view.
interface operand_stage_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_opa;
    logic [W-1:0]  in_opb;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          hi_force;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_opa, in_opb, flush, out_ready,
        output in_ready, out_valid, opa, opb, hi_force, count
    );

    modport master (
        output in_valid, in_opa, in_opb, flush, out_ready,
        input  in_ready, out_valid, opa, opb, hi_force, count
    );
endinterface

// File: rtl/operand_stage.sv
// Operand staging FIFO: buffers {opa, opb, hi_force} pairs with flush and a
// zero-latency head presentation; outputs are forced to zero while empty.
module operand_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    operand_stage_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         hf;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    // count never exceeds DEPTH (a power of two), so its MSB alone means full.
    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = !empty && bus.out_ready && !bus.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_opa, bus.in_opb,
                                bus.in_opa[W-2] | bus.in_opb[W-2]};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.opa       = empty ? '0 : head.a;
    assign bus.opb       = empty ? '0 : head.b;
    assign bus.hi_force  = empty ? 1'b0 : head.hf;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_operand_stage;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         hf;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    entry_t mq[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    operand_stage_if #(.W(W), .DEPTH(DEPTH)) bus ();

    operand_stage #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_opa();
        return (mq.size() != 0) ? mq[0].a : '0;
    endfunction
    function automatic logic [W-1:0] m_opb();
        return (mq.size() != 0) ? mq[0].b : '0;
    endfunction
    function automatic logic m_hf();
        return (mq.size() != 0) ? mq[0].hf : 1'b0;
    endfunction

    task automatic tick();
        bit     push, pop;
        entry_t e;
        push = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
        pop  = bus.out_ready && (mq.size() != 0) && !bus.flush;
        e.a  = bus.in_opa;
        e.b  = bus.in_opb;
        e.hf = bus.in_opa[W-2] | bus.in_opb[W-2];
        @(posedge clk);
        if (!rst_n || bus.flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.in_opa   = a;
        bus.in_opb   = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2 && mq.size() != 0; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_tests++; if (bus.opa !== '0 || bus.opb !== '0 || bus.hi_force !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got opa=%h opb=%h hf=%b expected 0/0/0", bus.opa, bus.opb, bus.hi_force);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        bus.out_ready = 1'b1;
        push_pair(32'h4000_0000, 32'h0000_0001);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        n_tests++; if (bus.opa !== 32'h4000_0000 || bus.opb !== 32'h0000_0001) begin
            n_fail++; $display("FAIL single_data: got %h/%h expected 40000000/00000001", bus.opa, bus.opb);
        end
        n_tests++; if (bus.hi_force !== 1'b1) begin n_fail++; $display("FAIL single_hf: got %b expected 1", bus.hi_force); end
        tick();
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL single_count_after: got %0d expected 0", bus.count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [W-1:0] exp;
        int           next_a, got, cyc;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_pair(W'(i), $urandom);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
        n_tests++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
        push_pair(32'd99, $urandom);
        n_tests++; if (bus.count !== CW'(4) || bus.opa !== 32'd1) begin
            n_fail++; $display("FAIL fill_fifth_ignored: got count=%0d opa=%0d expected 4/1", bus.count, bus.opa);
        end
        bus.out_ready = 1'b1;
        next_a = 5;
        got    = 1;
        cyc    = 0;
        while (got <= 6 && cyc < 30) begin
            bus.in_valid = (next_a <= 6);
            bus.in_opa   = W'(next_a);
            bus.in_opb   = $urandom;
            exp          = W'(got);
            n_tests++; if (bus.out_valid !== 1'b1 || bus.opa !== exp) begin
                n_fail++; $display("FAIL wrap_order: got valid=%b opa=%0d expected 1/%0d", bus.out_valid, bus.opa, exp);
            end
            if (bus.in_valid && mq.size() < DEPTH) next_a++;
            tick();
            got++;
            cyc++;
        end
        n_tests++; if (got <= 6) begin n_fail++; $display("FAIL wrap_timeout: got %0d outputs expected 6", got - 1); end
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL wrap_empty: got %0d expected 0", bus.count); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) push_pair($urandom, $urandom);
        bus.in_valid  = 1'b1;
        bus.in_opa    = 32'hFEED_0001;
        bus.out_ready = 1'b1;
        tick();
        n_tests++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 3", bus.count); end
        bus.in_opa = 32'hFEED_0002;
        tick();
        n_tests++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 3", bus.count); end
        n_tests++; if (bus.opa !== m_opa()) begin n_fail++; $display("FAIL pushpop_head: got %h expected %h", bus.opa, m_opa()); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b;
        b = $urandom;
        bus.out_ready = 1'b0;
        push_pair(32'h8000_0000, b);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (bus.opa !== 32'h8000_0000 || bus.opb !== b || bus.hi_force !== b[W-2] || bus.count !== CW'(1)) begin
                n_fail++; $display("FAIL hold: got %h/%h/%b/%0d expected 80000000/%h/%b/1", bus.opa, bus.opb, bus.hi_force, bus.count, b, b[W-2]);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair($urandom, $urandom);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_opa   = 32'hAA;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++; if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.opa !== '0) begin
            n_fail++; $display("FAIL flush: got count=%0d valid=%b opa=%h expected 0/0/0", bus.count, bus.out_valid, bus.opa);
        end
        push_pair(32'h55, 32'h0);
        n_tests++; if (bus.opa !== 32'h55 || bus.count !== CW'(1)) begin
            n_fail++; $display("FAIL flush_next: got opa=%h count=%0d expected 55/1", bus.opa, bus.count);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        n_tests++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL areset_pre: got %0d expected 2", bus.count); end
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.opa !== '0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL areset: got valid=%b count=%0d opa=%h rdy=%b expected 0/0/0/1", bus.out_valid, bus.count, bus.opa, bus.in_ready);
        end
        tick();
        rst_n = 1'b1;
        push_pair(32'h77, 32'h0);
        n_tests++; if (bus.opa !== 32'h77 || bus.count !== CW'(1)) begin
            n_fail++; $display("FAIL areset_first: got opa=%h count=%0d expected 77/1", bus.opa, bus.count);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 29) == 0);
            bus.in_opa    = $urandom;
            bus.in_opb    = $urandom;
            tick();
            n_tests++; if (bus.count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", bus.count, mq.size()); end
            n_tests++; if (bus.in_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_in_ready: got %b expected %b", bus.in_ready, mq.size() < DEPTH); end
            n_tests++; if (bus.out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_out_valid: got %b expected %b", bus.out_valid, mq.size() != 0); end
            n_tests++; if (bus.opa !== m_opa() || bus.opb !== m_opb()) begin
                n_fail++; $display("FAIL rand_data: got %h/%h expected %h/%h", bus.opa, bus.opb, m_opa(), m_opb());
            end
            n_tests++; if (bus.hi_force !== m_hf()) begin n_fail++; $display("FAIL rand_hf: got %b expected %b", bus.hi_force, m_hf()); end
        end
        bus.flush = 1'b0;
        drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_opa    = '0;
        bus.in_opb    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_pass();
        test_fill_wrap();
        test_full_pop();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
